// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, port indices and default widths
// for the three-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF  = 24;
    localparam int DATA_W_DEF  = 16;
    localparam int VID_MAX_DEF = 8;

    typedef logic [1:0] port_t;

    localparam port_t PORT_VID = 2'd0;
    localparam port_t PORT_CPU = 2'd1;
    localparam port_t PORT_AUX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_select.sv
// sdram_arb_select: picks the next port -- video first, CPU/AUX round-robin,
// with video preempted once it has won VID_MAX times while others waited.
module sdram_arb_select
    import sdram_arb_pkg::*;
#(
    parameter int VID_MAX = VID_MAX_DEF
) (
    input  logic [2:0] req,
    input  logic       rr_aux,
    input  logic [3:0] vid_run,
    output logic       gnt_valid,
    output port_t      gnt
);

    logic  other;
    logic  starve;
    port_t rr_pick;

    always_comb begin
        other     = req[PORT_CPU] | req[PORT_AUX];
        starve    = other && (vid_run == 4'(VID_MAX));
        rr_pick   = (req[PORT_CPU] && req[PORT_AUX]) ? (rr_aux ? PORT_AUX : PORT_CPU)
                  : (req[PORT_CPU] ? PORT_CPU : PORT_AUX);
        gnt_valid = |req;
        gnt       = (req[PORT_VID] && !starve) ? PORT_VID : rr_pick;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: serialises video, CPU and DMA requests onto one
// SDRAM controller command port, one transaction at a time.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int VID_MAX = VID_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_bytesel,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_bytesel,
    output logic              p1_ack,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    input  logic [1:0]        p2_bytesel,
    output logic              p2_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              ctrl_req,
    output logic              ctrl_we,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic [1:0]        ctrl_dqm,
    input  logic              ctrl_ack,
    input  logic [DATA_W-1:0] ctrl_rdata
);

    arb_state_t        state, state_nx;
    port_t             owner, gnt;
    logic              gnt_valid, rr_aux, other;
    logic [2:0]        req;
    logic [3:0]        vid_run, vid_run_nx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_bytesel;

    assign req   = {p2_req, p1_req, p0_req};
    assign other = p1_req | p2_req;

    sdram_arb_select #(
        .VID_MAX (VID_MAX)
    ) u_select (
        .req       (req),
        .rr_aux    (rr_aux),
        .vid_run   (vid_run),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    always_comb begin
        sel_we      = (gnt == PORT_VID) ? p0_we      : (gnt == PORT_CPU) ? p1_we      : p2_we;
        sel_addr    = (gnt == PORT_VID) ? p0_addr    : (gnt == PORT_CPU) ? p1_addr    : p2_addr;
        sel_wdata   = (gnt == PORT_VID) ? p0_wdata   : (gnt == PORT_CPU) ? p1_wdata   : p2_wdata;
        sel_bytesel = (gnt == PORT_VID) ? p0_bytesel : (gnt == PORT_CPU) ? p1_bytesel : p2_bytesel;
        // video streak only grows while someone else is actually waiting
        vid_run_nx  = (!other || gnt != PORT_VID) ? 4'd0
                    : (vid_run == 4'hF) ? vid_run : vid_run + 4'd1;
        state_nx    = (state == ST_IDLE && gnt_valid) ? ST_ISSUE
                    : (state == ST_ISSUE && ctrl_ack) ? ST_DONE
                    : (state == ST_DONE) ? ST_IDLE : state;
    end

    assign ctrl_req = (state == ST_ISSUE);
    assign p0_ack   = (state == ST_DONE) && (owner == PORT_VID);
    assign p1_ack   = (state == ST_DONE) && (owner == PORT_CPU);
    assign p2_ack   = (state == ST_DONE) && (owner == PORT_AUX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= PORT_VID;
            rr_aux     <= 1'b0;
            vid_run    <= '0;
            ctrl_we    <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_wdata <= '0;
            ctrl_dqm   <= 2'b11;
            rdata      <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE)
                vid_run <= vid_run_nx;
            if (state == ST_IDLE && gnt_valid) begin
                owner      <= gnt;
                ctrl_we    <= sel_we;
                ctrl_addr  <= sel_addr;
                ctrl_wdata <= sel_wdata;
                ctrl_dqm   <= ~sel_bytesel;
                if (gnt != PORT_VID)
                    rr_aux <= (gnt == PORT_CPU);
            end
            if (state == ST_ISSUE && ctrl_ack)
                rdata <= ctrl_rdata;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: random and directed traffic against a transaction-level
// model of the arbiter plus a behavioural downstream SDRAM controller.
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int VM = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    req_v = '0;
    logic [2:0]    we_v = '0;
    logic [AW-1:0] addr_v [3];
    logic [DW-1:0] wdata_v [3];
    logic [1:0]    bs_v [3];
    logic          a0, a1, a2;
    logic [2:0]    ack_v;
    logic [DW-1:0] rdata;
    logic          ctrl_req, ctrl_we;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_wdata;
    logic [1:0]    ctrl_dqm;
    logic          ctrl_ack = 1'b0;
    logic [DW-1:0] ctrl_rdata = '0;

    assign ack_v = {a2, a1, a0};

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VID_MAX(VM)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .p0_req     (req_v[0]),
        .p0_we      (we_v[0]),
        .p0_addr    (addr_v[0]),
        .p0_wdata   (wdata_v[0]),
        .p0_bytesel (bs_v[0]),
        .p0_ack     (a0),
        .p1_req     (req_v[1]),
        .p1_we      (we_v[1]),
        .p1_addr    (addr_v[1]),
        .p1_wdata   (wdata_v[1]),
        .p1_bytesel (bs_v[1]),
        .p1_ack     (a1),
        .p2_req     (req_v[2]),
        .p2_we      (we_v[2]),
        .p2_addr    (addr_v[2]),
        .p2_wdata   (wdata_v[2]),
        .p2_bytesel (bs_v[2]),
        .p2_ack     (a2),
        .rdata      (rdata),
        .ctrl_req   (ctrl_req),
        .ctrl_we    (ctrl_we),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_dqm   (ctrl_dqm),
        .ctrl_ack   (ctrl_ack),
        .ctrl_rdata (ctrl_rdata)
    );

    int checks = 0;
    int errors = 0;

    // transaction-level model: phase 0 idle, 1 command out, 2 ack
    int            phase, win, streak, last_rr, cnt, lat_fix, rd_fix;
    bit            auto_on;
    bit [2:0]      keep;
    int            prob [3];
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd;
    logic [1:0]    e_dqm;
    int            glog [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        phase = 0; win = 0; streak = 0; last_rr = 2; cnt = 0;
        lat_fix = -1; rd_fix = -1; auto_on = 0; keep = '0;
        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        glog.delete();
    endtask

    task automatic rand_cmd(input int i);
        we_v[i]    = 1'($urandom);
        addr_v[i]  = AW'($urandom);
        wdata_v[i] = DW'($urandom);
        bs_v[i]    = 2'($urandom);
    endtask

    function automatic int pick();
        bit oth = req_v[1] | req_v[2];
        int rr  = (req_v[1] && req_v[2]) ? (last_rr == 1 ? 2 : 1) : (req_v[1] ? 1 : 2);
        if (req_v[0] && !(oth && streak >= VM)) return 0;
        return rr;
    endfunction

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (phase == 2 && win == i) begin
                if (keep[i] || (auto_on && $urandom_range(0, 7) == 0)) rand_cmd(i);
                else req_v[i] = 1'b0;
            end else if (req_v[i]) begin
                if (auto_on && !keep[i] && $urandom_range(0, 31) == 0) req_v[i] = 1'b0;
            end else if (auto_on && int'($urandom_range(0, 99)) < prob[i]) begin
                req_v[i] = 1'b1;
                rand_cmd(i);
            end
        end
        ctrl_ack   = (phase == 1) ? (cnt == 0) : ($urandom_range(0, 3) == 0);
        if (phase == 1 && cnt > 0) cnt--;
        ctrl_rdata = (rd_fix >= 0) ? DW'(rd_fix) : DW'($urandom);
    endtask

    // drive this cycle's inputs and advance the model across the next rising edge
    task automatic commit();
        bit oth;
        drive();
        if (phase == 0) begin
            oth = req_v[1] | req_v[2];
            if (req_v != 0) begin
                win     = pick();
                e_we    = we_v[win];
                e_addr  = addr_v[win];
                e_wdata = wdata_v[win];
                e_dqm   = ~bs_v[win];
                if (win == 0) streak = oth ? streak + 1 : 0;
                else begin
                    streak  = 0;
                    last_rr = win;
                end
                cnt   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4));
                phase = 1;
            end else streak = 0;
        end else if (phase == 1) begin
            if (ctrl_ack) begin
                e_rd  = ctrl_rdata;
                phase = 2;
            end
        end else phase = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ctrl_req", ctrl_req, phase == 1);
        if (phase == 1) begin
            chk("ctrl_addr", ctrl_addr, e_addr);
            chk("ctrl_we", ctrl_we, e_we);
            chk("ctrl_wdata", ctrl_wdata, e_wdata);
            chk("ctrl_dqm", ctrl_dqm, e_dqm);
        end
        chk("ack", ack_v, phase == 2 ? 3'(1 << win) : 3'b000);
        if (phase == 2) chk("rdata", rdata, e_rd);
        for (int i = 0; i < 3; i++) if (ack_v[i]) glog.push_back(i);
    endtask

    task automatic step();
        tick();
        commit();
    endtask

    task automatic chk_order(input string tag, input int e [$]);
        chk({tag, "_count"}, glog.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk(tag, glog.size() > i ? glog[i] : -1, e[i]);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req_v    = '0;
        ctrl_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl_req", ctrl_req, 0);
        chk("rst_ack", ack_v, 0);
        chk("rst_ctrl_we", ctrl_we, 0);
        chk("rst_ctrl_addr", ctrl_addr, 0);
        chk("rst_ctrl_wdata", ctrl_wdata, 0);
        chk("rst_ctrl_dqm", ctrl_dqm, 2'b11);
        chk("rst_rdata", rdata, 0);
        reset_n = 1'b1;
        model_init();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_req, t_ack;
        logic [1:0] dqm_seen;
        int e [$];

        // single CPU read with 3-cycle downstream latency
        do_reset();
        lat_fix = 3; rd_fix = 16'hBEEF;
        req_v[1] = 1; we_v[1] = 0; addr_v[1] = 24'h000100; wdata_v[1] = '0; bs_v[1] = 2'b11;
        commit();
        t_req = -1; t_ack = -1; dqm_seen = 2'bxx;
        for (int k = 0; k < 30 && glog.size() < 1; k++) begin
            step();
            if (ctrl_req && t_req < 0) begin
                t_req = k;
                dqm_seen = ctrl_dqm;
                chk("s1_addr", ctrl_addr, 24'h000100);
            end
            if (a1) t_ack = k;
        end
        chk("s1_lat", t_ack - t_req, 4);
        chk("s1_rdata", rdata, 16'hBEEF);
        chk("s1_dqm", dqm_seen, 2'b00);

        // video and CPU together: video first
        do_reset();
        rand_cmd(0); rand_cmd(1); req_v[0] = 1; req_v[1] = 1;
        commit();
        for (int k = 0; k < 40 && glog.size() < 2; k++) step();
        e = {0, 1};
        chk_order("s2_order", e);

        // CPU and AUX held: strict alternation starting at CPU
        do_reset();
        keep = 3'b110;
        rand_cmd(1); rand_cmd(2); req_v[1] = 1; req_v[2] = 1;
        commit();
        for (int k = 0; k < 60 && glog.size() < 4; k++) step();
        e = {1, 2, 1, 2};
        chk_order("s3_order", e);

        // video hogging: CPU gets in after VID_MAX video grants
        do_reset();
        keep = 3'b001;
        rand_cmd(0); rand_cmd(1); req_v[0] = 1; req_v[1] = 1;
        commit();
        for (int k = 0; k < 150 && glog.size() < 10; k++) step();
        e = {0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        chk_order("s4_order", e);

        // AUX upper-byte write held stable until ack
        do_reset();
        lat_fix = 5;
        rand_cmd(2); we_v[2] = 1; wdata_v[2] = 16'h12AB; bs_v[2] = 2'b10; req_v[2] = 1;
        commit();
        for (int k = 0; k < 10 && !ctrl_req; k++) step();
        chk("s5_dqm", ctrl_dqm, 2'b01);
        chk("s5_we", ctrl_we, 1);
        chk("s5_wdata", ctrl_wdata, 16'h12AB);
        for (int k = 0; k < 20 && glog.size() < 1; k++) step();
        e = {2};
        chk_order("s5_order", e);

        // reset in the middle of a transaction
        do_reset();
        lat_fix = 8;
        rand_cmd(1); req_v[1] = 1;
        commit();
        for (int k = 0; k < 10 && !ctrl_req; k++) step();
        chk("s6_pre_req", ctrl_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("s6_async_req", ctrl_req, 0);
        chk("s6_async_ack", ack_v, 0);
        chk("s6_async_dqm", ctrl_dqm, 2'b11);
        req_v = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_init();
        commit();
        for (int k = 0; k < 12; k++) step();
        chk("s6_no_ack", glog.size(), 0);

        // random mixed traffic
        do_reset();
        auto_on = 1; prob[0] = 40; prob[1] = 40; prob[2] = 40;
        commit();
        repeat (3000) step();

        // random traffic with video streaming continuously
        do_reset();
        auto_on = 1; keep = 3'b001; prob[0] = 100; prob[1] = 30; prob[2] = 30;
        commit();
        repeat (2000) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning the SDRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the SDRAM data width.
REQ-003 SHALL have parameter VID_MAX, default 8, meaning the maximum number of consecutive video grants while another port waits.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports clk and reset_n are listed first.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have ports pN_req (N=0..2), input, 1 bit each: request. Port 0 is video, port 1 is CPU, port 2 is DMA/spare.
REQ-008 SHALL have ports pN_we, input, 1 bit each: write=1, read=0.
REQ-009 SHALL have ports pN_addr, input, ADDR_W bits each: word address.
REQ-010 SHALL have ports pN_wdata, input, DATA_W bits each: write data.
REQ-011 SHALL have ports pN_bytesel, input, 2 bits each: byte enables, active-high, bit1=upper byte.
REQ-012 SHALL have ports pN_ack, output, 1 bit each: one-cycle completion pulse.
REQ-013 SHALL have port rdata, output, DATA_W bits: read data shared by all ports, valid in the cycle of the granted port's ack.
REQ-014 SHALL have ctrl_req / ctrl_we / ctrl_addr / ctrl_wdata, outputs, widths 1 / 1 / ADDR_W / DATA_W: downstream command.
REQ-015 SHALL have ctrl_dqm, output, 2 bits: downstream byte mask, active-low (= ~bytesel).
REQ-016 SHALL have ctrl_ack, input, 1 bit: downstream completion.
REQ-017 SHALL have ctrl_rdata, input, DATA_W bits: downstream read data, valid with ctrl_ack.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-019 SHALL, in IDLE with any req high, latch the winner's we/addr/wdata/bytesel and enter ISSUE on the next edge; otherwise it stays in IDLE.
REQ-020 SHALL hold ctrl_req=1 and the latched command stable throughout ISSUE, and deassert ctrl_req in all other states.
REQ-021 SHALL, on ctrl_ack in ISSUE, register ctrl_rdata into rdata and enter DONE.
REQ-022 SHALL pulse the winner's pN_ack for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL give latency, req rising in IDLE to ctrl_req, of 1 cycle, and ctrl_ack to pN_ack of 1 cycle.
REQ-024 SHALL never arbitrate in the DONE cycle, so a req still high at ack is not re-granted for the same transaction.
REQ-025 SHALL treat a req still high in the IDLE cycle after DONE as a new transaction.
REQ-026 SHALL give port 0 priority over ports 1 and 2.
REQ-027 SHALL grant ports 1 and 2 round-robin: a 1-bit pointer toggles to the other port after each port-1/2 grant; on reset the pointer favours port 1.
REQ-028 SHALL keep a 4-bit vid_run counter: +1 on a port-0 grant while port 1 or 2 req is high (saturating); cleared on any port-1/2 grant or when no other req is pending.
REQ-029 SHALL, when vid_run == VID_MAX and a port-1/2 req is pending, give that grant precedence over port 0.
REQ-030 SHALL leave the outstanding grant unaffected when a requester drops req mid-transaction; the transaction completes and the ack is still pulsed.
REQ-031 SHALL ignore ctrl_ack outside ISSUE.
REQ-032 SHALL, on simultaneous req on all ports with vid_run below VID_MAX, grant port 0.

Reset
REQ-033 SHALL, while reset_n=0, force state=IDLE, all pN_ack=0, ctrl_req=0, ctrl_we=0, ctrl_addr=0, ctrl_wdata=0, ctrl_dqm=2'b11, rdata=0, vid_run=0 and rr pointer=port1, asynchronously.
REQ-034 SHALL, on reset asserted mid-transaction, abandon the transaction with no ack generated; the downstream controller is reset by the same reset_n.

Structure
REQ-035 SHALL place the state encoding, the port index constants (PORT_VID=0, PORT_CPU=1, PORT_AUX=2) and the default widths in shared package sdram_arb_pkg.
REQ-036 SHALL place the priority/round-robin/starvation selection in one combinational sub-module, sdram_arb_select, with the FSM and registers in the parent.

Verification
REQ-037 SHALL cover: p1 read of addr 0x000100, ctrl_ack 3 cycles after ctrl_req with ctrl_rdata 0xBEEF -> p1_ack one cycle later, rdata=0xBEEF, ctrl_dqm=2'b00.
REQ-038 SHALL cover: p0 and p1 request in the same cycle -> p0 granted first, p1 granted in the following IDLE.
REQ-039 SHALL cover: p1 and p2 held high for 4 transactions -> grant order p1,p2,p1,p2.
REQ-040 SHALL cover: p0 continuously requesting plus p1 pending, VID_MAX=8 -> p1 granted after the 8th p0 grant, then p0 resumes.
REQ-041 SHALL cover: p2 byte write with bytesel=2'b10, wdata=0x12AB -> ctrl_dqm=2'b01, ctrl_we=1, ctrl_wdata=0x12AB stable until ctrl_ack.
REQ-042 SHALL cover: reset_n pulled low in ISSUE -> ctrl_req=0 and state IDLE immediately, no pN_ack pulse after release.
